// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              disp_num,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_ON, ST_GAP} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [CNT_W-1:0]             cnt;
  logic [NUM_DIGITS-1:0][3:0]   shadow;
  logic [NUM_DIGITS-1:0][3:0]   pending;
  logic                         pend_full;
  logic                         accept;
  logic                         blank;

  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;

  // NOTE: shadow and pending are small register banks, not RAM, so they take the
  // asynchronous reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_GAP;
      idx       <= IDX_LAST;
      cnt       <= '0;
      shadow    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order in this block.
      if (accept) begin
        pending   <= load_data;
        pend_full <= 1'b1;
      end
      case (state)
        ST_ON: begin
          if (cnt == ON_LAST) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_ON;
            cnt   <= '0;
            if (idx == IDX_LAST) begin
              idx <= '0;
              // Frame boundary: pend_full is set here only when accept was low,
              // so this clear never races a same-edge load.
              if (pend_full) begin
                shadow    <= pending;
                pend_full <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // lz[i] is set when digits i..NUM_DIGITS-1 of the shown value are all zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves lz unassigned (no latch).
    lz = '0;
    lz[NUM_DIGITS-1] = (shadow[NUM_DIGITS-1] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (shadow[i] == 4'h0);
    end
  end

  assign blank = (idx != '0) && lz[idx];
`else
  assign blank = 1'b0;
`endif

  // Outputs decode straight from the registered state: no added latency.
  always_comb begin
    an          = '1;
    disp_num    = 4'hF;
    frame_start = (state == ST_ON) && (idx == '0) && (cnt == '0);
    if (state == ST_ON && !blank) begin
      an       = ~(NUM_DIGITS'(1) << idx);
      disp_num = shadow[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: outputs are compared every cycle against a
// timeline model that derives digit/slot position from elapsed cycles.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int REF   = 4;
  localparam int GAP   = 1;
  localparam int SLOT  = REF + GAP;
  localparam int FRAME = ND * SLOT;
  localparam int ITERS = 2500;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_data;
  logic [3:0]      disp_num;
  logic [ND-1:0]   an;
  logic            frame_start;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset release plus the displayed/pending values.
  int          c;
  logic [15:0] sh_m;
  logic [15:0] pe_m;
  bit          pf_m;
  bit          want_reset;
  int          resets_done;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(REF),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .disp_num   (disp_num),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, cycle %0d)", tag, obs, exp, $time, c);
    end
  endtask

  task automatic model_reset();
    c    = 0;
    sh_m = '0;
    pe_m = '0;
    pf_m = 1'b0;
  endtask

  // Where in the timeline cycle c falls: lit digit (or -1 when blank gap).
  function automatic int lit_digit(input int cyc);
    int p;
    if (cyc < GAP) return -1;
    p = (cyc - GAP) % FRAME;
    if ((p % SLOT) >= REF) return -1;
    return p / SLOT;
  endfunction

  function automatic bit is_frame_first(input int cyc);
    return (cyc >= GAP) && (((cyc - GAP) % FRAME) == 0);
  endfunction

  task automatic check_outputs();
    int          d;
    logic [3:0]  nib;
    logic [3:0]  exp_an;
    logic [3:0]  exp_num;
    bit          blanked;
    d       = lit_digit(c);
    exp_an  = 4'hF;
    exp_num = 4'hF;
    if (d >= 0) begin
      nib     = 4'((sh_m >> (4 * d)) & 16'hF);
      blanked = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      blanked = (d > 0) && ((sh_m >> (4 * d)) == 16'h0);
`endif
      if (!blanked) begin
        exp_an  = ~(4'b0001 << d);
        exp_num = nib;
      end
    end
    check("an", 32'(an), 32'(exp_an));
    check("disp_num", 32'(disp_num), 32'(exp_num));
    check("frame_start", 32'(frame_start), 32'(is_frame_first(c)));
    check("load_ready", 32'(load_ready), 32'(!pf_m));
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit old_pf;
    old_pf = pf_m;
    if (is_frame_first(c + 1) && old_pf) begin
      sh_m = pe_m;
      pf_m = 1'b0;
    end
    if (load_valid && !old_pf) begin
      pe_m = load_data;
      pf_m = 1'b1;
    end
    c++;
  endtask

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 6))
      0:       return 16'h1234;
      1:       return 16'h5678;
      2:       return 16'h00AF;
      3:       return 16'h0045;
      4:       return 16'h0000;
      5:       return 16'h0009;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_in_reset();
    check("rst_an", 32'(an), 32'hF);
    check("rst_disp_num", 32'(disp_num), 32'hF);
    check("rst_load_ready", 32'(load_ready), 32'h1);
    check("rst_frame_start", 32'(frame_start), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    want_reset  = 1'b0;
    resets_done = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_in_reset();
    rst = 1'b0;

    for (int it = 0; it < ITERS; it++) begin
      check_outputs();

      if (it == 700 || it == 1800) want_reset = 1'b1;
      // Reset asserted asynchronously in the middle of digit 2's ON slot.
      if (want_reset && lit_digit(c) == 2) begin
        want_reset = 1'b0;
        resets_done++;
        load_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_in_reset();
        @(negedge clk);
        check_in_reset();
        rst = 1'b0;
        model_reset();
        continue;
      end

      // Sparse valids leave loads idle for a while; denser bursts force stalls.
      if (it % 400 < 200) load_valid = ($urandom_range(0, 15) == 0);
      else                load_valid = ($urandom_range(0, 2) == 0);
      load_data = pick_data();

      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    check("mid_run_resets", 32'(resets_done), 32'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
